// File: rtl/l1c_pkg.sv
// Shared constants and types for the L1 cache line refill sequencer.
// Widths follow the CPU wrapper's DATA_BITS / CACHE_INDEX_BITS settings.
package l1c_pkg;

    localparam int DATA_BITS        = 32;
    localparam int CACHE_INDEX_BITS = 6;
    localparam int LINE_WORDS       = 4;
    localparam int LINE_OFF_BITS    = 4;

    // Memory-port access type for a single cached word read.
    localparam logic [2:0] CACHE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMMIT
    } refill_state_e;

endpackage

// File: rtl/l1c_lane_web_dec.sv
// Turns a word-lane number into the active-low byte write-enable
// of the 128-bit data array row; all ones when no write is pending.
module l1c_lane_web_dec (
    input  logic        en_i,
    input  logic [1:0]  lane_i,
    output logic [15:0] web_o
);

    always_comb begin
        web_o = 16'hFFFF;
        if (en_i) begin
            web_o[{lane_i, 2'b00} +: 4] = 4'b0000;
        end
    end

endmodule

// File: rtl/l1c_line_refill.sv
// Critical-word-first refill sequencer: fetches a 4-word line, forwards the
// critical word, writes each lane one cycle after it arrives, then commits the tag.
module l1c_line_refill
    import l1c_pkg::*;
#(
    parameter int ADDR_W     = DATA_BITS,
    parameter int LINE_WORDS = l1c_pkg::LINE_WORDS,
    parameter int INDEX_W    = CACHE_INDEX_BITS,
    parameter int TAG_W      = ADDR_W - INDEX_W - LINE_OFF_BITS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       miss_req_i,
    input  logic [ADDR_W-1:0]          miss_addr_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       crit_valid_o,
    output logic [ADDR_W-1:0]          crit_data_o,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [2:0]                 mem_type_o,
    output logic                       mem_write_o,
    input  logic [ADDR_W-1:0]          mem_out_i,
    input  logic                       mem_wait_i,
    output logic [INDEX_W-1:0]         da_index_o,
    output logic [ADDR_W*LINE_WORDS-1:0] da_in_o,
    output logic [15:0]                da_web_o,
    output logic [TAG_W-1:0]           ta_in_o,
    output logic                       ta_web_o,
    output logic                       valid_set_o
);

    refill_state_e      state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  wr_data_q, wr_data_d;
    logic [1:0]         wr_lane_q, wr_lane_d;
    logic               wr_pend_q, wr_pend_d;

    logic               accept;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^miss_addr_i[1:0];
    assign accept           = (state_q == FETCH) && !mem_wait_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            index_q   <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            wr_data_q <= '0;
            wr_lane_q <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            wr_data_q <= wr_data_d;
            wr_lane_q <= wr_lane_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        index_d   = index_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        wr_data_d = wr_data_q;
        wr_lane_d = wr_lane_q;
        wr_pend_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss_req_i) begin
                    tag_d   = miss_addr_i[ADDR_W-1 -: TAG_W];
                    index_d = miss_addr_i[LINE_OFF_BITS +: INDEX_W];
                    off_d   = miss_addr_i[3:2];
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (accept) begin
                    wr_data_d = mem_out_i;
                    wr_lane_d = off_q;
                    wr_pend_d = 1'b1;
                    off_d     = off_q + 2'd1;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'(LINE_WORDS - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The data array has one row per line; the word is copied to every lane
    // and the byte enables pick which lane actually takes it.
    l1c_lane_web_dec u_web_dec (
        .en_i   (wr_pend_q),
        .lane_i (wr_lane_q),
        .web_o  (da_web_o)
    );

    assign da_in_o      = {LINE_WORDS{wr_data_q}};
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == COMMIT);
    assign valid_set_o  = (state_q == COMMIT);
    assign ta_web_o     = (state_q != COMMIT);
    assign ta_in_o      = tag_q;
    assign da_index_o   = busy_o ? index_q : '0;

    assign mem_req_o    = (state_q == FETCH);
    assign mem_addr_o   = mem_req_o ? {tag_q, index_q, off_q, 2'b00} : '0;
    assign mem_type_o   = CACHE_WORD;
    assign mem_write_o  = 1'b0;

    assign crit_valid_o = accept && (cnt_q == 2'd0);
    assign crit_data_o  = crit_valid_o ? mem_out_i : '0;

endmodule

// File: tb/tb_l1c_line_refill.sv
// Scoreboard bench for l1c_line_refill: directed refills push expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_l1c_line_refill;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy, done, crit_valid;
    logic [31:0]  crit_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [2:0]   mem_type;
    logic         mem_write;
    logic [31:0]  mem_out;
    logic         mem_wait = 1'b0;
    logic [5:0]   da_index;
    logic [127:0] da_in;
    logic [15:0]  da_web;
    logic [21:0]  ta_in;
    logic         ta_web;
    logic         valid_set;

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;
    int stallFrom  = -1;
    int stallTo    = -1;
    int lastStart  = 0;

    logic [31:0]  addrQ[$];
    logic [31:0]  critDataQ[$];
    int           critCycQ[$];
    logic [15:0]  laneWebQ[$];
    logic [127:0] laneDataQ[$];
    logic [5:0]   laneIdxQ[$];
    logic [21:0]  doneTagQ[$];
    logic [5:0]   doneIdxQ[$];
    int           doneCycQ[$];

    l1c_line_refill dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .miss_req_i   (miss_req),
        .miss_addr_i  (miss_addr),
        .busy_o       (busy),
        .done_o       (done),
        .crit_valid_o (crit_valid),
        .crit_data_o  (crit_data),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_type_o   (mem_type),
        .mem_write_o  (mem_write),
        .mem_out_i    (mem_out),
        .mem_wait_i   (mem_wait),
        .da_index_o   (da_index),
        .da_in_o      (da_in),
        .da_web_o     (da_web),
        .ta_in_o      (ta_in),
        .ta_web_o     (ta_web),
        .valid_set_o  (valid_set)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stall window is expressed in cycle numbers so it lines up with cyc.
    always @(posedge clk) begin
        #1;
        mem_wait = (cyc >= stallFrom) && (cyc < stallTo);
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [15:0] laneWeb(input logic [1:0] lane);
        logic [15:0] w;
        case (lane)
            2'd0:    w = 16'hFFF0;
            2'd1:    w = 16'hFF0F;
            2'd2:    w = 16'hF0FF;
            default: w = 16'h0FFF;
        endcase
        return w;
    endfunction

    assign mem_out = memData(mem_addr);

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr,
                                 input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3,
                                 input logic [21:0] tag, input logic [5:0] idx,
                                 input int stallWord, input int stallLen);
        logic [31:0] e[4];
        int s;
        e = '{e0, e1, e2, e3};
        miss_addr = addr;
        miss_req  = 1'b1;
        s = cyc + 1;
        lastStart = s;
        for (int i = 0; i < 4; i++) begin
            addrQ.push_back(e[i]);
            laneWebQ.push_back(laneWeb(e[i][3:2]));
            laneDataQ.push_back({4{memData(e[i])}});
            laneIdxQ.push_back(idx);
        end
        critDataQ.push_back(memData(e0));
        critCycQ.push_back(s);
        doneTagQ.push_back(tag);
        doneIdxQ.push_back(idx);
        doneCycQ.push_back(s + 4 + stallLen);
        if (stallLen > 0) begin
            stallFrom = s + stallWord;
            stallTo   = s + stallWord + stallLen;
        end else begin
            stallFrom = -1;
            stallTo   = -1;
        end
        nextCycle();
        miss_req = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (doneCycQ.size() != 0 && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput("drainInBudget", 128'(doneCycQ.size()), 128'(0));
    endtask

    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (mem_req && !mem_wait) begin
                checkOutput("acceptExpected", 128'(addrQ.size() != 0), 128'(1));
                if (addrQ.size() != 0) checkOutput("memAddr", 128'(mem_addr), 128'(addrQ.pop_front()));
            end
            if (mem_req && mem_wait && addrQ.size() != 0)
                checkOutput("stallAddrHold", 128'(mem_addr), 128'(addrQ[0]));
            if (crit_valid) begin
                checkOutput("critExpected", 128'(critDataQ.size() != 0), 128'(1));
                if (critDataQ.size() != 0) begin
                    checkOutput("critData", 128'(crit_data), 128'(critDataQ.pop_front()));
                    checkOutput("critCycle", 128'(cyc), 128'(critCycQ.pop_front()));
                end
            end
            if (da_web != 16'hFFFF) begin
                checkOutput("laneExpected", 128'(laneWebQ.size() != 0), 128'(1));
                if (laneWebQ.size() != 0) begin
                    checkOutput("laneWeb", 128'(da_web), 128'(laneWebQ.pop_front()));
                    checkOutput("laneData", da_in, laneDataQ.pop_front());
                    checkOutput("laneIndex", 128'(da_index), 128'(laneIdxQ.pop_front()));
                end
            end
            if (done) begin
                checkOutput("doneExpected", 128'(doneCycQ.size() != 0), 128'(1));
                if (doneCycQ.size() != 0) begin
                    checkOutput("tagIn", 128'(ta_in), 128'(doneTagQ.pop_front()));
                    checkOutput("tagWeb", 128'(ta_web), 128'(0));
                    checkOutput("validSet", 128'(valid_set), 128'(1));
                    checkOutput("doneIndex", 128'(da_index), 128'(doneIdxQ.pop_front()));
                    checkOutput("doneCycle", 128'(cyc), 128'(doneCycQ.pop_front()));
                end
            end else if (valid_set || !ta_web) begin
                checkOutput("strayTagWrite", 128'({valid_set, ta_web}), 128'(2'b01));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s1;
        rst_ni    = 1'b0;
        miss_req  = 1'b0;
        miss_addr = '0;
        repeat (3) nextCycle();

        checkOutput("rstBusy", 128'(busy), 128'(0));
        checkOutput("rstDone", 128'(done), 128'(0));
        checkOutput("rstCrit", 128'(crit_valid), 128'(0));
        checkOutput("rstMemReq", 128'(mem_req), 128'(0));
        checkOutput("rstMemAddr", 128'(mem_addr), 128'(0));
        checkOutput("rstDaWeb", 128'(da_web), 128'(16'hFFFF));
        checkOutput("rstTaWeb", 128'(ta_web), 128'(1));
        checkOutput("rstValidSet", 128'(valid_set), 128'(0));
        checkOutput("rstDaIndex", 128'(da_index), 128'(0));
        checkOutput("memWrite", 128'(mem_write), 128'(0));
        checkOutput("memType", 128'(mem_type), 128'(3'b010));

        rst_ni = 1'b1;
        nextCycle();

        $display("[TB] refill 0x1238, no stall");
        applyStimulus(32'h0000_1238, 32'h1238, 32'h123C, 32'h1230, 32'h1234, 22'h4, 6'h23, 0, 0);
        checkOutput("busyFetch", 128'(busy), 128'(1));
        waitDrain(20);
        nextCycle();

        $display("[TB] refill 0x1238, 3-cycle stall on word 2");
        applyStimulus(32'h0000_1238, 32'h1238, 32'h123C, 32'h1230, 32'h1234, 22'h4, 6'h23, 2, 3);
        waitDrain(20);
        nextCycle();

        $display("[TB] refill 0x004C, offset 3 wrap");
        applyStimulus(32'h0000_004C, 32'h004C, 32'h0040, 32'h0044, 32'h0048, 22'h0, 6'h04, 0, 0);
        waitDrain(20);
        nextCycle();

        $display("[TB] miss_req while busy and on done cycle");
        applyStimulus(32'h0000_ABC4, 32'hABC4, 32'hABC8, 32'hABCC, 32'hABC0, 22'h2A, 6'h3C, 0, 0);
        nextCycle();
        miss_req  = 1'b1;
        miss_addr = 32'h0000_5550;
        checkOutput("busyIgnored", 128'(busy), 128'(1));
        nextCycle();
        miss_req = 1'b0;
        checkOutput("busyStill", 128'(busy), 128'(1));
        while (cyc < lastStart + 4) nextCycle();
        checkOutput("doneHighNow", 128'(done), 128'(1));
        miss_req  = 1'b1;
        miss_addr = 32'h0000_7770;
        nextCycle();
        miss_req = 1'b0;
        checkOutput("doneCycleReqIgnored", 128'(busy), 128'(0));
        repeat (3) nextCycle();
        checkOutput("stillIdle", 128'(busy), 128'(0));
        waitDrain(5);

        $display("[TB] back-to-back refills");
        applyStimulus(32'h0000_1238, 32'h1238, 32'h123C, 32'h1230, 32'h1234, 22'h4, 6'h23, 0, 0);
        s1 = lastStart;
        while (cyc < s1 + 5) nextCycle();
        checkOutput("idleGap", 128'(busy), 128'(0));
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                      22'h3F_FFFF, 6'h3F, 0, 0);
        checkOutput("backToBackBusy", 128'(busy), 128'(1));
        waitDrain(20);
        nextCycle();

        $display("[TB] reset after two accepts");
        applyStimulus(32'h0000_2008, 32'h2008, 32'h200C, 32'h2000, 32'h2004, 22'h8, 6'h00, 0, 0);
        nextCycle();
        rst_ni = 1'b0;
        nextCycle();
        checkOutput("abortMemReq", 128'(mem_req), 128'(0));
        checkOutput("abortTaWeb", 128'(ta_web), 128'(1));
        checkOutput("abortDaWeb", 128'(da_web), 128'(16'hFFFF));
        checkOutput("abortValidSet", 128'(valid_set), 128'(0));
        checkOutput("abortBusy", 128'(busy), 128'(0));
        checkOutput("abortUnfetched", 128'(addrQ.size()), 128'(2));
        checkOutput("abortUnwritten", 128'(laneWebQ.size()), 128'(3));
        checkOutput("abortCritSeen", 128'(critDataQ.size()), 128'(0));
        addrQ.delete();
        laneWebQ.delete();
        laneDataQ.delete();
        laneIdxQ.delete();
        critDataQ.delete();
        critCycQ.delete();
        doneTagQ.delete();
        doneIdxQ.delete();
        doneCycQ.delete();
        repeat (2) begin
            nextCycle();
            checkOutput("heldValidSet", 128'(valid_set), 128'(0));
        end
        rst_ni = 1'b1;
        repeat (4) begin
            nextCycle();
            checkOutput("postAbortValidSet", 128'(valid_set), 128'(0));
        end

        checkOutput("leftoverAccepts", 128'(addrQ.size()), 128'(0));
        checkOutput("leftoverLanes", 128'(laneWebQ.size()), 128'(0));
        checkOutput("leftoverCrit", 128'(critDataQ.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
